// File: rtl/my_div2.sv
// Registered divide-by-two for the ALU: shifts an operand right by one bit
// (logical or arithmetic) and exports the shifted-out LSB as the remainder.
module my_div2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             arith,
    input  logic [WIDTH-1:0] op1,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             out_valid
);

    logic             fill;
    logic [WIDTH-1:0] quotient;

    // Sign-extending the MSB in arithmetic mode rounds toward -inf, so -1 >> 1 stays -1.
    always_comb begin
        fill     = arith & op1[WIDTH-1];
        quotient = {fill, op1[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out  <= quotient;
                cout <= op1[0];
            end
        end
    end

endmodule

// File: tb/tb_my_div2.sv
// Directed and random checks for my_div2: reset, both shift modes, boundaries,
// back-to-back throughput, reset priority and hold behaviour.
module tb_my_div2;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       arith;
    logic [7:0] op1;
    logic [7:0] out;
    logic       cout;
    logic       out_valid;

    int checks = 0;
    int errors = 0;

    my_div2 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .arith     (arith),
        .op1       (op1),
        .out       (out),
        .cout      (cout),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] eo, input logic ec, input logic ev);
        checks++;
        assert ({out, cout, out_valid} === {eo, ec, ev}) else begin
            errors++;
            $error("FAIL %s out=%h cout=%b valid=%b expected out=%h cout=%b valid=%b",
                   tag, out, cout, out_valid, eo, ec, ev);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]        eo;
        logic              ec;
        logic              ev;
        logic signed [7:0] s;

        // 1) reset for two cycles, then idle
        rst = 1'b1; in_valid = 1'b0; arith = 1'b0; op1 = 8'h00;
        tick(); tick();
        check("reset", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        check("idle_after_reset", 8'h00, 1'b0, 1'b0);

        // 2) simple logical shift
        in_valid = 1'b1; arith = 1'b0; op1 = 8'h0E;
        tick();
        check("log_0E", 8'h07, 1'b0, 1'b1);

        // 3) 0xAB logical then arithmetic
        op1 = 8'hAB; arith = 1'b0;
        tick();
        check("log_AB", 8'h55, 1'b1, 1'b1);
        arith = 1'b1;
        tick();
        check("ari_AB", 8'hD5, 1'b1, 1'b1);

        // 4) back-to-back boundaries
        op1 = 8'h00; arith = 1'b0;
        tick();
        check("b2b_00", 8'h00, 1'b0, 1'b1);
        op1 = 8'hFF; arith = 1'b0;
        tick();
        check("b2b_FF_log", 8'h7F, 1'b1, 1'b1);
        op1 = 8'hFF; arith = 1'b1;
        tick();
        check("b2b_FF_ari", 8'hFF, 1'b1, 1'b1);

        // op1 = 1 in both modes
        op1 = 8'h01; arith = 1'b0;
        tick();
        check("one_log", 8'h00, 1'b1, 1'b1);
        arith = 1'b1;
        tick();
        check("one_ari", 8'h00, 1'b1, 1'b1);
        op1 = 8'h80; arith = 1'b1;
        tick();
        check("ari_80", 8'hC0, 1'b0, 1'b1);
        op1 = 8'h80; arith = 1'b0;
        tick();
        check("log_80", 8'h40, 1'b0, 1'b1);

        // 5) reset wins over in_valid
        op1 = 8'hAB; arith = 1'b0; rst = 1'b1;
        tick();
        check("rst_priority", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;

        // 6) hold after a result while inputs wander or go unknown
        op1 = 8'h3C; arith = 1'b0;
        tick();
        check("pre_hold", 8'h1E, 1'b0, 1'b1);
        in_valid = 1'b0; op1 = 8'hC3; arith = 1'b1;
        tick();
        check("hold_1", 8'h1E, 1'b0, 1'b0);
        op1 = 8'hxx; arith = 1'bx;
        tick();
        check("hold_x", 8'h1E, 1'b0, 1'b0);

        // random traffic against an independent signed/unsigned division model
        eo = 8'h1E; ec = 1'b0; ev = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            in_valid = ($urandom_range(3) != 0);
            arith    = 1'($urandom_range(1));
            op1      = 8'($urandom_range(255));
            if (in_valid) begin
                s  = $signed(op1);
                eo = arith ? 8'(s >>> 1) : (op1 / 8'd2);
                ec = op1 % 2;
            end
            ev = in_valid;
            tick();
            check("random", eo, ec, ev);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
